// File: rtl/tile_loader_13x13.sv
// Tile loader: fetches 43 words of a 13x13 byte tile from feature memory into the tile buffer.
// Optional running byte checksum outputs are enabled with `define TILE_LOADER_CHECKSUM_EN.
module tile_loader_13x13 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] base_addr,
    output logic        busy,
    output logic        done,
    output logic        mem_rd_req,
    output logic [15:0] mem_addr,
    input  logic        mem_rd_valid,
    input  logic [31:0] mem_rd_data,
    output logic        buf_en,
    output logic [31:0] buf_address,
    output logic [7:0]  buf_data0,
    output logic [7:0]  buf_data1,
    output logic [7:0]  buf_data2,
    output logic [7:0]  buf_data3
`ifdef TILE_LOADER_CHECKSUM_EN
    ,
    output logic [15:0] checksum,
    output logic        checksum_valid
`endif
);

    localparam int unsigned TILE_DIM  = 13;
    localparam int unsigned NUM_WORDS = (TILE_DIM * TILE_DIM + 3) / 4;
    localparam int unsigned MEM_AW    = 16;
    localparam int unsigned IDX_W     = $clog2(NUM_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [MEM_AW-1:0]   base_q, base_d;
    logic                capture;
    logic                busy_d, done_d, req_d;
    logic [MEM_AW-1:0]   addr_d;

    // Next-state and next-output logic; all outputs are registered from these.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        base_d  = base_q;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    idx_d   = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_rd_valid) begin
                    capture = 1'b1;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = IDX_W'(idx_q + IDX_W'(1));
                    state_d = S_REQ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        req_d  = (state_d == S_REQ);
        addr_d = MEM_AW'(base_d + MEM_AW'(idx_d));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            base_q      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            mem_rd_req  <= 1'b0;
            mem_addr    <= '0;
            buf_en      <= 1'b0;
            buf_address <= '0;
            buf_data0   <= '0;
            buf_data1   <= '0;
            buf_data2   <= '0;
            buf_data3   <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            base_q     <= base_d;
            busy       <= busy_d;
            done       <= done_d;
            mem_rd_req <= req_d;
            mem_addr   <= addr_d;
            buf_en     <= capture;
            // Buffer address/data hold between writes.
            if (capture) begin
                buf_address <= 32'(idx_q);
                buf_data0   <= mem_rd_data[7:0];
                buf_data1   <= mem_rd_data[15:8];
                buf_data2   <= mem_rd_data[23:16];
                buf_data3   <= mem_rd_data[31:24];
            end
        end
    end

`ifdef TILE_LOADER_CHECKSUM_EN
    logic [15:0] cs_d;

    // Sum of tile bytes; the final word contributes only its byte 0.
    always_comb begin
        cs_d = checksum;
        if (state_q == S_IDLE && start) begin
            cs_d = '0;
        end else if (state_q == S_WRITE) begin
            if (idx_q == LAST_IDX) begin
                cs_d = 16'(checksum + 16'(buf_data0));
            end else begin
                cs_d = 16'(checksum + 16'(buf_data0) + 16'(buf_data1)
                                    + 16'(buf_data2) + 16'(buf_data3));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum       <= '0;
            checksum_valid <= 1'b0;
        end else begin
            checksum       <= cs_d;
            checksum_valid <= done_d;
        end
    end
`endif

endmodule
